// File: rtl/lock_pkg.sv
// ============================================================================
// Module  : lock_pkg
// Brief   : Shared state encoding, widths and helpers for the sequence lock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lock_pkg;

    localparam logic [1:0] ENTRY    = 2'd0;
    localparam logic [1:0] UNLOCKED = 2'd1;
    localparam logic [1:0] LOCKOUT  = 2'd2;

    typedef enum logic [1:0] {
        ST_ENTRY    = ENTRY,
        ST_UNLOCKED = UNLOCKED,
        ST_LOCKOUT  = LOCKOUT
    } state_t;

    localparam int FAIL_W = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_lock_if.sv
// ============================================================================
// Module  : seq_lock_if
// Brief   : Key, code-load and status signals of the sequence lock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_lock_if
    import lock_pkg::*;
#(
    parameter int CODE_LEN = 4
);
    logic                inp0;
    logic                inp1;
    logic [CODE_LEN-1:0] code_in;
    logic                code_load;
    logic                out;
    logic                alarm;
    logic [FAIL_W-1:0]   fail_cnt;

    modport master (
        output inp0, inp1, code_in, code_load,
        input  out, alarm, fail_cnt
    );

    modport slave (
        input  inp0, inp1, code_in, code_load,
        output out, alarm, fail_cnt
    );

endinterface

`default_nettype wire

// File: rtl/lock_timer.sv
// ============================================================================
// Module  : lock_timer
// Brief   : Loadable saturating down-counter; done_o while the count is zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lock_timer #(
    parameter int WIDTH = 6
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] value_i,
    output logic                  done_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/seq_lock.sv
// ============================================================================
// Module  : seq_lock
// Brief   : Two-key sequence lock with unlock window, retry lockout and idle
//           discard of partial entries; one shared interval timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_lock
    import lock_pkg::*;
#(
    parameter int                CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] DEFAULT_CODE = 4'b0110,
    parameter int                MAX_TRIES      = 3,
    parameter int                UNLOCK_CYCLES  = 8,
    parameter int                LOCKOUT_CYCLES = 16,
    parameter int                IDLE_TIMEOUT   = 32
) (
    input  wire logic clock,
    input  wire logic reset,
    seq_lock_if.slave bus
);

    localparam int TMR_MAX = max3(UNLOCK_CYCLES, LOCKOUT_CYCLES, IDLE_TIMEOUT);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CNT_W   = $clog2(CODE_LEN + 1);

    state_t              state_q;
    logic [CODE_LEN-2:0] entry_q;
    logic [CODE_LEN-1:0] code_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [FAIL_W-1:0]   fail_q;
    logic                out_q;
    logic                alarm_q;

    logic                w_one;
    logic                w_both;
    logic [CODE_LEN-1:0] w_shift;
    logic                w_last;
    logic                w_match;
    logic [FAIL_W-1:0]   w_fail_inc;
    logic                w_lock;
    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_value;
    logic                w_tmr_done;

    assign w_one      = bus.inp0 ^ bus.inp1;
    assign w_both     = bus.inp0 & bus.inp1;
    // Only CODE_LEN-1 digits are ever held; the newest digit completes the word.
    assign w_shift    = {entry_q, bus.inp1};
    assign w_last     = (cnt_q == CNT_W'(CODE_LEN - 1));
    assign w_match    = (w_shift == code_q);
    assign w_fail_inc = fail_q + 1'b1;
    assign w_lock     = (w_fail_inc == FAIL_W'(MAX_TRIES));

    // Reload values are N-1 because the exit decision is taken on the edge
    // that finds the counter already at zero.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = TMR_W'(IDLE_TIMEOUT - 1);
        if (state_q == ST_ENTRY && w_one) begin
            w_tmr_load = 1'b1;
            if (w_last && w_match) begin
                w_tmr_value = TMR_W'(UNLOCK_CYCLES - 1);
            end else if (w_last && w_lock) begin
                w_tmr_value = TMR_W'(LOCKOUT_CYCLES - 1);
            end
        end
    end

    lock_timer #(
        .WIDTH   (TMR_W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load_i  (w_tmr_load),
        .value_i (w_tmr_value),
        .done_o  (w_tmr_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_ENTRY;
            entry_q <= '0;
            code_q  <= DEFAULT_CODE;
            cnt_q   <= '0;
            fail_q  <= '0;
            out_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (w_both) begin
                        cnt_q   <= '0;
                        entry_q <= '0;
                    end else if (w_one) begin
                        if (w_last) begin
                            cnt_q   <= '0;
                            entry_q <= '0;
                            if (w_match) begin
                                state_q <= ST_UNLOCKED;
                                out_q   <= 1'b1;
                                fail_q  <= '0;
                            end else begin
                                fail_q <= w_fail_inc;
                                if (w_lock) begin
                                    state_q <= ST_LOCKOUT;
                                    alarm_q <= 1'b1;
                                end
                            end
                        end else begin
                            entry_q <= w_shift[CODE_LEN-2:0];
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end else if (cnt_q != '0 && w_tmr_done) begin
                        cnt_q   <= '0;
                        entry_q <= '0;
                    end
                end
                ST_UNLOCKED: begin
                    if (bus.code_load) begin
                        code_q <= bus.code_in;
                    end
                    if (w_tmr_done) begin
                        state_q <= ST_ENTRY;
                        out_q   <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_tmr_done) begin
                        state_q <= ST_ENTRY;
                        alarm_q <= 1'b0;
                        fail_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_ENTRY;
                    out_q   <= 1'b0;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out      = out_q;
    assign bus.alarm    = alarm_q;
    assign bus.fail_cnt = fail_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_lock.sv
// ============================================================================
// Module  : tb_seq_lock
// Brief   : Self-checking bench for seq_lock against a queue-based lock model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_lock;

    localparam int            CL   = 4;
    localparam logic [CL-1:0] DEF  = 4'b0110;
    localparam int            MAXT = 3;
    localparam int            UNL  = 8;
    localparam int            LCK  = 16;
    localparam int            IDLE = 32;

    // Stimulus codes: 0/1 digit, 2 idle, 3 both keys, 4 code_load, 5 reset
    localparam int D0 = 0, D1 = 1, DI = 2, DB = 3, DL = 4, DR = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    seq_lock_if #(.CODE_LEN(CL)) bus ();

    seq_lock #(
        .CODE_LEN       (CL),
        .DEFAULT_CODE   (DEF),
        .MAX_TRIES      (MAXT),
        .UNLOCK_CYCLES  (UNL),
        .LOCKOUT_CYCLES (LCK),
        .IDLE_TIMEOUT   (IDLE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: digits typed so far, plain remaining-cycle counters.
    int            m_digits[$];
    int            m_idle  = 0;
    int            m_fails = 0;
    int            m_unl   = 0;
    int            m_lock  = 0;
    logic [CL-1:0] m_code  = DEF;

    task automatic model_edge(input logic rst, input logic i0, input logic i1,
                              input logic ld, input logic [CL-1:0] cin);
        if (rst) begin
            m_digits.delete();
            m_idle = 0; m_fails = 0; m_unl = 0; m_lock = 0; m_code = DEF;
        end else if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) begin
                m_fails = 0;
                m_digits.delete();
                m_idle = 0;
            end
        end else if (m_unl > 0) begin
            if (ld) m_code = cin;
            m_unl--;
        end else if (i0 && i1) begin
            m_digits.delete();
            m_idle = 0;
        end else if (i0 || i1) begin
            m_digits.push_back(i1 ? 1 : 0);
            m_idle = 0;
            if (m_digits.size() == CL) begin
                int v;
                v = 0;
                foreach (m_digits[k]) v = v * 2 + m_digits[k];
                m_digits.delete();
                if (v == int'(m_code)) begin
                    m_unl   = UNL;
                    m_fails = 0;
                end else begin
                    m_fails++;
                    if (m_fails == MAXT) m_lock = LCK;
                end
            end
        end else if (m_digits.size() > 0) begin
            m_idle++;
            if (m_idle == IDLE) begin
                m_digits.delete();
                m_idle = 0;
            end
        end
    endtask

    task automatic apply(input int d, input logic [CL-1:0] cin);
        reset         = (d == DR);
        bus.inp0      = (d == D0 || d == DB);
        bus.inp1      = (d == D1 || d == DB);
        bus.code_load = (d == DL);
        bus.code_in   = cin;
        @(posedge clock);
        model_edge(reset, bus.inp0, bus.inp1, bus.code_load, bus.code_in);
        #1;
    endtask

    task automatic push_n(ref int q[$], input int d, input int n);
        for (int k = 0; k < n; k++) q.push_back(d);
    endtask

    task automatic test_reset();
        apply(DR, '0);
        apply(DR, '0);
        checks++;
        if (bus.out !== 1'b0 || bus.alarm !== 1'b0 || bus.fail_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset: out=%b alarm=%b fail_cnt=%0d, expected 0 0 0",
                     bus.out, bus.alarm, bus.fail_cnt);
        end
    endtask

    task automatic test_unlock();
        int seq[$];
        int hi;
        hi  = 0;
        seq = '{D0, D1, D1, D0};
        push_n(seq, DI, 12);
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i], '0);
            if (bus.out === 1'b1) hi++;
            checks++;
            if (bus.out !== (m_unl > 0) || bus.alarm !== (m_lock > 0) || bus.fail_cnt !== 4'(m_fails)) begin
                errors++;
                $display("FAIL unlock step %0d: out=%b alarm=%b fail_cnt=%0d, expected %b %b %0d",
                         i, bus.out, bus.alarm, bus.fail_cnt, m_unl > 0, m_lock > 0, m_fails);
            end
        end
        checks++;
        if (hi !== UNL) begin
            errors++;
            $display("FAIL unlock_len: out high %0d cycles, expected %0d", hi, UNL);
        end
    endtask

    task automatic test_lockout();
        int seq[$];
        int al;
        int out_seen;
        al = 0; out_seen = 0;
        push_n(seq, D1, 12);
        seq.push_back(DL);
        seq.push_back(D0); seq.push_back(D1); seq.push_back(D1); seq.push_back(D0);
        push_n(seq, DI, 14);
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i], 4'b1111);
            if (bus.alarm === 1'b1) al++;
            if (bus.out === 1'b1) out_seen++;
            checks++;
            if (bus.out !== (m_unl > 0) || bus.alarm !== (m_lock > 0) || bus.fail_cnt !== 4'(m_fails)) begin
                errors++;
                $display("FAIL lockout step %0d: out=%b alarm=%b fail_cnt=%0d, expected %b %b %0d",
                         i, bus.out, bus.alarm, bus.fail_cnt, m_unl > 0, m_lock > 0, m_fails);
            end
        end
        checks++;
        if (al !== LCK || out_seen !== 0 || bus.fail_cnt !== 4'd0) begin
            errors++;
            $display("FAIL lockout_len: alarm %0d cycles out %0d cycles fail_cnt=%0d, expected %0d 0 0",
                     al, out_seen, bus.fail_cnt, LCK);
        end
    endtask

    task automatic test_abort();
        int seq[$];
        int hi;
        hi  = 0;
        seq = '{D0, D1, DB, DL, D0, D1, D1, D0};
        push_n(seq, DI, 10);
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i], 4'b1001);
            if (bus.out === 1'b1) hi++;
            checks++;
            if (bus.out !== (m_unl > 0) || bus.alarm !== (m_lock > 0) || bus.fail_cnt !== 4'(m_fails)) begin
                errors++;
                $display("FAIL abort step %0d: out=%b alarm=%b fail_cnt=%0d, expected %b %b %0d",
                         i, bus.out, bus.alarm, bus.fail_cnt, m_unl > 0, m_lock > 0, m_fails);
            end
        end
        checks++;
        if (hi !== UNL || bus.fail_cnt !== 4'd0) begin
            errors++;
            $display("FAIL abort_unlock: out high %0d cycles fail_cnt=%0d, expected %0d 0",
                     hi, bus.fail_cnt, UNL);
        end
    endtask

    task automatic test_idle();
        int seq[$];
        int hi;
        int fmax;
        hi = 0; fmax = 0;
        seq = '{D0, D1};
        push_n(seq, DI, IDLE - 1);
        seq.push_back(D1); seq.push_back(D0);
        push_n(seq, DI, 10);
        seq.push_back(D0); seq.push_back(D1);
        push_n(seq, DI, IDLE);
        seq.push_back(D1); seq.push_back(D0);
        push_n(seq, DI, IDLE);
        seq.push_back(D0); seq.push_back(D1); seq.push_back(D1); seq.push_back(D0);
        push_n(seq, DI, 10);
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i], '0);
            if (bus.out === 1'b1) hi++;
            if (int'(bus.fail_cnt) > fmax) fmax = int'(bus.fail_cnt);
            checks++;
            if (bus.out !== (m_unl > 0) || bus.alarm !== (m_lock > 0) || bus.fail_cnt !== 4'(m_fails)) begin
                errors++;
                $display("FAIL idle step %0d: out=%b alarm=%b fail_cnt=%0d, expected %b %b %0d",
                         i, bus.out, bus.alarm, bus.fail_cnt, m_unl > 0, m_lock > 0, m_fails);
            end
        end
        checks++;
        if (hi !== 2 * UNL || fmax !== 0) begin
            errors++;
            $display("FAIL idle_summary: out high %0d cycles max fail_cnt %0d, expected %0d 0",
                     hi, fmax, 2 * UNL);
        end
    endtask

    task automatic test_code_load();
        int seq[$];
        int hi;
        int f_after;
        hi = 0; f_after = -1;
        seq = '{D0, D1, D1, D0, DI, DL};
        push_n(seq, DI, 10);
        seq.push_back(D0); seq.push_back(D1); seq.push_back(D1); seq.push_back(D0);
        seq.push_back(D1); seq.push_back(D0); seq.push_back(D0); seq.push_back(D1);
        push_n(seq, DI, 10);
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i], 4'b1001);
            if (bus.out === 1'b1) hi++;
            if (i == 19) f_after = int'(bus.fail_cnt);
            checks++;
            if (bus.out !== (m_unl > 0) || bus.alarm !== (m_lock > 0) || bus.fail_cnt !== 4'(m_fails)) begin
                errors++;
                $display("FAIL code_load step %0d: out=%b alarm=%b fail_cnt=%0d, expected %b %b %0d",
                         i, bus.out, bus.alarm, bus.fail_cnt, m_unl > 0, m_lock > 0, m_fails);
            end
        end
        checks++;
        if (hi !== 2 * UNL || f_after !== 1) begin
            errors++;
            $display("FAIL code_load_summary: out high %0d cycles fail after old code %0d, expected %0d 1",
                     hi, f_after, 2 * UNL);
        end
    endtask

    task automatic test_reset_in_lockout();
        int seq[$];
        push_n(seq, D1, 12);
        push_n(seq, DI, 3);
        for (int i = 0; i < seq.size(); i++) begin
            apply(seq[i], '0);
            checks++;
            if (bus.out !== (m_unl > 0) || bus.alarm !== (m_lock > 0) || bus.fail_cnt !== 4'(m_fails)) begin
                errors++;
                $display("FAIL rst_lock step %0d: out=%b alarm=%b fail_cnt=%0d, expected %b %b %0d",
                         i, bus.out, bus.alarm, bus.fail_cnt, m_unl > 0, m_lock > 0, m_fails);
            end
        end
        apply(DR, '0);
        checks++;
        if (bus.alarm !== 1'b0 || bus.fail_cnt !== 4'd0 || bus.out !== 1'b0) begin
            errors++;
            $display("FAIL rst_lock_reset: out=%b alarm=%b fail_cnt=%0d, expected 0 0 0",
                     bus.out, bus.alarm, bus.fail_cnt);
        end
        apply(D0, '0); apply(D1, '0); apply(D1, '0); apply(D0, '0);
        checks++;
        if (bus.out !== 1'b1 || bus.fail_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_lock_code: out=%b fail_cnt=%0d, expected 1 0 (default code restored)",
                     bus.out, bus.fail_cnt);
        end
        repeat (UNL) apply(DI, '0);
    endtask

    task automatic test_random();
        int d;
        int r;
        logic [CL-1:0] cin;
        for (int i = 0; i < 4000; i++) begin
            r   = int'($urandom_range(0, 199));
            cin = CL'($urandom_range(0, (1 << CL) - 1));
            if (r < 80)       d = D0;
            else if (r < 160) d = D1;
            else if (r < 166) d = DB;
            else if (r < 188) d = DI;
            else if (r < 199) d = DL;
            else              d = DR;
            apply(d, cin);
            checks++;
            if (bus.out !== (m_unl > 0) || bus.alarm !== (m_lock > 0) || bus.fail_cnt !== 4'(m_fails)
                || (bus.out & bus.alarm) !== 1'b0) begin
                errors++;
                $display("FAIL random step %0d: out=%b alarm=%b fail_cnt=%0d, expected %b %b %0d",
                         i, bus.out, bus.alarm, bus.fail_cnt, m_unl > 0, m_lock > 0, m_fails);
            end
        end
    endtask

    initial begin
        bus.inp0      = 1'b0;
        bus.inp1      = 1'b0;
        bus.code_in   = '0;
        bus.code_load = 1'b0;
        test_reset();
        test_unlock();
        test_lockout();
        test_abort();
        test_idle();
        test_code_load();
        test_reset_in_lockout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
